// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: round-robin grant of NUM_REQ result buses onto the
// single register-file write port, plus the register busy scoreboard.
module riscv_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_rd,
    input  logic [XLEN*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic                    wb_stall,
    input  logic                    issue_valid,
    input  logic [4:0]              issue_rd,
    input  logic                    flush,
    output logic                    rf_we,
    output logic [4:0]              rf_rd,
    output logic [XLEN-1:0]         rf_wdata,
    output logic [31:0]             busy
);

    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1 = PW + 1;

    logic [PW-1:0]   ptr_q;
    logic            rf_we_q;
    logic [4:0]      rf_rd_q;
    logic [XLEN-1:0] rf_wdata_q;
    logic [31:0]     busy_q;
    logic [31:0]     busy_d;

    logic [4:0]      rd_a   [NUM_REQ];
    logic [XLEN-1:0] data_a [NUM_REQ];

    logic            found;
    logic [PW-1:0]   gnt_idx;
    logic            allow;
    logic            hs;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign rd_a[g]   = req_rd[5*g +: 5];
        assign data_a[g] = req_data[XLEN*g +: XLEN];
    end

    // First valid requester searching upward from the slot after the last grant.
    always_comb begin
        logic [PW:0] idx;
        found   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + PW1'(k);
            if (idx >= PW1'(NUM_REQ)) begin
                idx = idx - PW1'(NUM_REQ);
            end
            if (!found && req_valid[idx[PW-1:0]]) begin
                found   = 1'b1;
                gnt_idx = idx[PW-1:0];
            end
        end
    end

    assign allow = !rst && !wb_stall && !flush;
    assign hs    = found && allow;

    // One-hot grant; only ever depends on valids, stall, flush and the pointer.
    always_comb begin
        req_ready = '0;
        if (hs) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_rd   = rd_a[gnt_idx];
    assign sel_data = data_a[gnt_idx];

    // Scoreboard next state: clear on writeback, set on issue wins, flush wipes all.
    always_comb begin
        busy_d = busy_q;
        if (hs && sel_rd != 5'd0) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (issue_valid && issue_rd != 5'd0) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Pointer, registered write port and scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= PW'(NUM_REQ - 1);
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            busy_q <= busy_d;
            if (hs) begin
                ptr_q      <= gnt_idx;
                rf_rd_q    <= sel_rd;
                rf_wdata_q <= sel_data;
                rf_we_q    <= (sel_rd != 5'd0);
            end else begin
                rf_we_q <= 1'b0;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign busy     = busy_q;

endmodule
